// File: rtl/pipeline_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
// Bundle between the 5-stage pipeline datapath/decode side and the hazard
// sequencer.
//   master : pipeline side. Drives hazard inputs, receives enables/flushes.
//   slave  : hazard sequencer. Receives hazard inputs, drives enables/flushes.
// Signals
//   ID_Rs, ID_Rt, ID_UsesRt, ID_Jump      decode-stage instruction info
//   EX_MemRead, EX_Rt, EX_BranchTaken     execute-stage instruction info
//   MEM_MemReq, MEM_Ready                 data-memory handshake
//   PCWrite, IFID_Write, IFID_Flush,
//   IDEX_Write, IDEX_Flush, EXMEM_Write,
//   MEMWB_Flush, PCSrcSel, MemErr         pipeline-register controls / status
// -----------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if #(
    parameter int REG_AW = 5
);
    logic [REG_AW-1:0] ID_Rs;
    logic [REG_AW-1:0] ID_Rt;
    logic              ID_UsesRt;
    logic              ID_Jump;
    logic              EX_MemRead;
    logic [REG_AW-1:0] EX_Rt;
    logic              EX_BranchTaken;
    logic              MEM_MemReq;
    logic              MEM_Ready;

    logic              PCWrite;
    logic              IFID_Write;
    logic              IFID_Flush;
    logic              IDEX_Write;
    logic              IDEX_Flush;
    logic              EXMEM_Write;
    logic              MEMWB_Flush;
    logic [1:0]        PCSrcSel;
    logic              MemErr;

    modport master (
        output ID_Rs, ID_Rt, ID_UsesRt, ID_Jump,
        output EX_MemRead, EX_Rt, EX_BranchTaken,
        output MEM_MemReq, MEM_Ready,
        input  PCWrite, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush,
        input  EXMEM_Write, MEMWB_Flush, PCSrcSel, MemErr
    );

    modport slave (
        input  ID_Rs, ID_Rt, ID_UsesRt, ID_Jump,
        input  EX_MemRead, EX_Rt, EX_BranchTaken,
        input  MEM_MemReq, MEM_Ready,
        output PCWrite, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush,
        output EXMEM_Write, MEMWB_Flush, PCSrcSel, MemErr
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Hazard and stall sequencer for a 5-stage MIPS pipeline with forwarding.
// Drives write/flush enables of PC, IF/ID, ID/EX, EX/MEM and MEM/WB for
// load-use stalls, taken-branch / jump flushes and data-memory wait states.
// A memory access stalled for MEM_TIMEOUT cycles halts the pipeline and sets
// the sticky MemErr flag; only Reset_L leaves HALT.
//
// Ports
//   CLK        pipeline clock, rising edge
//   Reset_L    asynchronous active-low reset
//   hzBus      pipeline_hazard_ctrl_if.slave (hazard inputs, enables, MemErr)
//   StallCycles, FlushCount  (only with HAZ_PERF_CNT_EN) saturating counters
//
// Configuration macro
//   HAZ_PERF_CNT_EN : adds StallCycles[15:0] / FlushCount[15:0] counters.
//
// Priority of events, highest first:
//   HALT > mem stall > branch flush > load-use > jump
// Enables/flushes are combinational from state and inputs; state, wait
// counter, MemErr (and perf counters) are registered.
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int REG_AW      = 5,
    parameter int TMO_W       = 8,
    parameter int MEM_TIMEOUT = 200
) (
    input  logic                         CLK,
    input  logic                         Reset_L,
`ifdef HAZ_PERF_CNT_EN
    output logic [15:0]                  StallCycles,
    output logic [15:0]                  FlushCount,
`endif
    pipeline_hazard_ctrl_if.slave        hzBus
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        HALT     = 2'b10
    } state_e;

    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(MEM_TIMEOUT);
    localparam logic [TMO_W-1:0] CNT_ZERO  = {TMO_W{1'b0}};
    localparam logic [TMO_W-1:0] CNT_ONE   = {{(TMO_W-1){1'b0}}, 1'b1};

    state_e            state_r;
    state_e            stateNext_s;
    logic [TMO_W-1:0]  waitCnt_r;
    logic [TMO_W-1:0]  waitCntNext_s;
    logic [TMO_W-1:0]  waitCntInc_s;
    logic              memErr_r;
    logic              memErrNext_s;

    logic              memStall_s;
    logic              loadUse_s;
    logic              branch_s;
    logic              jump_s;
    logic              active_s;

    // Raw hazard detection; register $0 is hard-wired zero and never stalls.
    always_comb begin
        memStall_s = hzBus.MEM_MemReq & ~hzBus.MEM_Ready;
        branch_s   = hzBus.EX_BranchTaken;
        jump_s     = hzBus.ID_Jump;
        loadUse_s  = hzBus.EX_MemRead
                   & (hzBus.EX_Rt != {REG_AW{1'b0}})
                   & ((hzBus.ID_Rs == hzBus.EX_Rt)
                      | (hzBus.ID_UsesRt & (hzBus.ID_Rt == hzBus.EX_Rt)));
        active_s   = (state_r == RUN) | (state_r == MEM_WAIT);
        waitCntInc_s = waitCnt_r + CNT_ONE;
    end

    // State, wait counter and sticky error register.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state_r   <= RUN;
            waitCnt_r <= CNT_ZERO;
            memErr_r  <= 1'b0;
        end else begin
            state_r   <= stateNext_s;
            waitCnt_r <= waitCntNext_s;
            memErr_r  <= memErrNext_s;
        end
    end

    // Next-state logic: count stalled cycles, halt once the limit is reached.
    always_comb begin
        stateNext_s   = state_r;
        waitCntNext_s = waitCnt_r;
        memErrNext_s  = memErr_r;
        case (state_r)
            RUN, MEM_WAIT: begin
                if (memStall_s) begin
                    waitCntNext_s = waitCntInc_s;
                    if (waitCntInc_s >= TMO_LIMIT) begin
                        stateNext_s  = HALT;
                        memErrNext_s = 1'b1;
                    end else begin
                        stateNext_s  = MEM_WAIT;
                    end
                end else begin
                    stateNext_s   = RUN;
                    waitCntNext_s = CNT_ZERO;
                end
            end
            HALT: begin
                stateNext_s = HALT;
            end
            default: begin
                // Corrupted state encoding: freeze the pipeline and flag it.
                stateNext_s  = HALT;
                memErrNext_s = 1'b1;
            end
        endcase
    end

    // Output logic: pipeline-register enables/flushes and PC source select.
    always_comb begin
        hzBus.PCWrite     = 1'b0;
        hzBus.IFID_Write  = 1'b0;
        hzBus.IFID_Flush  = 1'b1;
        hzBus.IDEX_Write  = 1'b0;
        hzBus.IDEX_Flush  = 1'b1;
        hzBus.EXMEM_Write = 1'b0;
        hzBus.MEMWB_Flush = 1'b1;
        hzBus.PCSrcSel    = 2'b00;
        // Reset is applied combinationally too so outputs freeze immediately.
        if (Reset_L && active_s) begin
            hzBus.PCWrite     = 1'b1;
            hzBus.IFID_Write  = 1'b1;
            hzBus.IFID_Flush  = 1'b0;
            hzBus.IDEX_Write  = 1'b1;
            hzBus.IDEX_Flush  = 1'b0;
            hzBus.EXMEM_Write = 1'b1;
            hzBus.MEMWB_Flush = 1'b0;
            if (memStall_s) begin
                // Freeze everything upstream of MEM; bubble into WB.
                hzBus.PCWrite     = 1'b0;
                hzBus.IFID_Write  = 1'b0;
                hzBus.IDEX_Write  = 1'b0;
                hzBus.EXMEM_Write = 1'b0;
                hzBus.MEMWB_Flush = 1'b1;
            end else if (branch_s) begin
                // Squashes any load-use or jump of the wrong-path instruction.
                hzBus.PCSrcSel    = 2'b01;
                hzBus.IFID_Flush  = 1'b1;
                hzBus.IDEX_Flush  = 1'b1;
            end else if (loadUse_s) begin
                hzBus.PCWrite     = 1'b0;
                hzBus.IFID_Write  = 1'b0;
                hzBus.IDEX_Flush  = 1'b1;
            end else if (jump_s) begin
                hzBus.PCSrcSel    = 2'b10;
                hzBus.IFID_Flush  = 1'b1;
            end else begin
                hzBus.PCSrcSel    = 2'b00;
            end
        end else begin
            hzBus.PCSrcSel = 2'b00;
        end
    end

    assign hzBus.MemErr = memErr_r;

`ifdef HAZ_PERF_CNT_EN
    logic        stallEvt_s;
    logic        flushEvt_s;
    logic [15:0] stallCnt_r;
    logic [15:0] flushCnt_r;

    // Events that actually take effect after priority resolution.
    always_comb begin
        stallEvt_s = active_s & (memStall_s | (loadUse_s & ~branch_s));
        flushEvt_s = active_s & ~memStall_s & (branch_s | (jump_s & ~loadUse_s));
    end

    // Saturating performance counters.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            stallCnt_r <= 16'h0000;
            flushCnt_r <= 16'h0000;
        end else begin
            if (stallEvt_s && (stallCnt_r != 16'hFFFF)) begin
                stallCnt_r <= stallCnt_r + 16'h0001;
            end
            if (flushEvt_s && (flushCnt_r != 16'hFFFF)) begin
                flushCnt_r <= flushCnt_r + 16'h0001;
            end
        end
    end

    assign StallCycles = stallCnt_r;
    assign FlushCount  = flushCnt_r;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Self-checking bench: directed table of single-cycle vectors, hand-written
// multi-cycle sequences (memory wait, timeout/HALT, reset mid-wait) and a
// randomized run checked against a behavioural model.
// Output vector order: {PCWrite, IFID_Write, IFID_Flush, IDEX_Write,
//                       IDEX_Flush, EXMEM_Write, MEMWB_Flush, PCSrcSel[1:0]}
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    localparam int MEM_TIMEOUT = 200;

    localparam logic [8:0] RST_O = 9'b0_0_1_0_1_0_1_00;
    localparam logic [8:0] DEF_O = 9'b1_1_0_1_0_1_0_00;
    localparam logic [8:0] MST_O = 9'b0_0_0_0_0_0_1_00;
    localparam logic [8:0] BR_O  = 9'b1_1_1_1_1_1_0_01;
    localparam logic [8:0] LU_O  = 9'b0_0_0_1_1_1_0_00;
    localparam logic [8:0] JMP_O = 9'b1_1_1_1_0_1_0_10;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       usesRt;
        logic       jump;
        logic       memRead;
        logic [4:0] exRt;
        logic       br;
        logic       memReq;
        logic       ready;
    } vec_t;

    typedef struct {
        vec_t       v;
        logic [8:0] exp;
        string      name;
    } rec_t;

    logic CLK;
    logic Reset_L;
    int   nCmp;
    int   nBad;

    // behavioural model state
    int   mWait;
    bit   mHalted;
    bit   mMemErr;

    pipeline_hazard_ctrl_if #(.REG_AW(5)) hz ();

`ifdef HAZ_PERF_CNT_EN
    logic [15:0] stallCycles;
    logic [15:0] flushCount;
`endif

    pipeline_hazard_ctrl #(
        .REG_AW(5),
        .TMO_W(8),
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) dut (
        .CLK(CLK),
        .Reset_L(Reset_L),
`ifdef HAZ_PERF_CNT_EN
        .StallCycles(stallCycles),
        .FlushCount(flushCount),
`endif
        .hzBus(hz)
    );

    logic [8:0] outVec;
    assign outVec = {hz.PCWrite, hz.IFID_Write, hz.IFID_Flush, hz.IDEX_Write,
                     hz.IDEX_Flush, hz.EXMEM_Write, hz.MEMWB_Flush, hz.PCSrcSel};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic vec_t mkVec(input logic [4:0] rs, input logic [4:0] rt,
                                   input logic usesRt, input logic jump,
                                   input logic memRead, input logic [4:0] exRt,
                                   input logic br, input logic memReq,
                                   input logic ready);
        vec_t v;
        v.rs = rs; v.rt = rt; v.usesRt = usesRt; v.jump = jump;
        v.memRead = memRead; v.exRt = exRt; v.br = br;
        v.memReq = memReq; v.ready = ready;
        return v;
    endfunction

    // Expected outputs from the priority rules and the model's HALT flag.
    function automatic logic [8:0] modelOut(input vec_t v);
        if (!Reset_L || mHalted) return RST_O;
        if (v.memReq && !v.ready) return MST_O;
        if (v.br) return BR_O;
        if (v.memRead && (v.exRt != 5'd0) &&
            ((v.rs == v.exRt) || (v.usesRt && (v.rt == v.exRt)))) return LU_O;
        if (v.jump) return JMP_O;
        return DEF_O;
    endfunction

    // Advance the model by one clock edge.
    task automatic modelTick(input vec_t v);
        if (!Reset_L) begin
            mWait = 0; mHalted = 1'b0; mMemErr = 1'b0;
        end else if (!mHalted) begin
            if (v.memReq && !v.ready) begin
                mWait = mWait + 1;
                if (mWait >= MEM_TIMEOUT) begin
                    mHalted = 1'b1;
                    mMemErr = 1'b1;
                end
            end else begin
                mWait = 0;
            end
        end
    endtask

    task automatic drive(input vec_t v);
        hz.ID_Rs = v.rs; hz.ID_Rt = v.rt; hz.ID_UsesRt = v.usesRt;
        hz.ID_Jump = v.jump; hz.EX_MemRead = v.memRead; hz.EX_Rt = v.exRt;
        hz.EX_BranchTaken = v.br; hz.MEM_MemReq = v.memReq;
        hz.MEM_Ready = v.ready;
    endtask

    task automatic chk(input string name, input logic [9:0] act,
                       input logic [9:0] exp);
        nCmp = nCmp + 1;
        if (act !== exp) begin
            nBad = nBad + 1;
            $display("FAIL %s: got %b required %b", name, act, exp);
        end
    endtask

    // One cycle: drive at negedge, compare, then let the edge happen.
    task automatic step(input vec_t v, input logic [8:0] expO,
                        input logic expErr, input string name);
        @(negedge CLK);
        drive(v);
        #1;
        chk(name, {outVec, hz.MemErr}, {expO, expErr});
        @(posedge CLK);
        modelTick(v);
    endtask

    rec_t tbl[12];
    vec_t idle;
    vec_t stall;
    vec_t rdy;
    vec_t rv;

    initial begin
        nCmp = 0; nBad = 0;
        mWait = 0; mHalted = 1'b0; mMemErr = 1'b0;
        idle  = mkVec(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        stall = mkVec(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        rdy   = mkVec(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);

        //                    rs     rt     uRt   jmp   mRd   exRt   br    mReq  rdy
        tbl[0]  = '{mkVec(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0), DEF_O, "idle"};
        tbl[1]  = '{mkVec(5'd5, 5'd1, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0), LU_O,  "lu_rs"};
        tbl[2]  = '{mkVec(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0), DEF_O, "lu_r0"};
        tbl[3]  = '{mkVec(5'd3, 5'd7, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0), LU_O,  "lu_rt"};
        tbl[4]  = '{mkVec(5'd3, 5'd7, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0), DEF_O, "lu_rt_unused"};
        tbl[5]  = '{mkVec(5'd5, 5'd1, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0), BR_O,  "br_over_lu"};
        tbl[6]  = '{mkVec(5'd2, 5'd4, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0), JMP_O, "jump"};
        tbl[7]  = '{mkVec(5'd6, 5'd1, 1'b0, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0), LU_O,  "lu_over_jump"};
        tbl[8]  = '{mkVec(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0), BR_O,  "br_over_jump"};
        tbl[9]  = '{mkVec(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1), JMP_O, "memrdy_jump"};
        tbl[10] = '{mkVec(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0), MST_O, "mst_over_br"};
        tbl[11] = '{mkVec(5'd9, 5'd0, 1'b0, 1'b0, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0), DEF_O, "no_load"};

        // reset state
        Reset_L = 1'b0;
        drive(idle);
        #3;
        chk("reset_out", {outVec, hz.MemErr}, {RST_O, 1'b0});
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        Reset_L = 1'b1;

        // directed table
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].v, tbl[i].exp, 1'b0, tbl[i].name);
        end

        // memory wait: 3 freeze cycles, then advance and back to RUN
        for (int i = 0; i < 3; i++) step(stall, MST_O, 1'b0, "memwait_freeze");
        step(rdy,  DEF_O, 1'b0, "memwait_done");
        step(idle, DEF_O, 1'b0, "memwait_run");

        // reset asserted mid-wait aborts immediately
        step(stall, MST_O, 1'b0, "rstwait_pre1");
        step(stall, MST_O, 1'b0, "rstwait_pre2");
        @(negedge CLK);
        #2 Reset_L = 1'b0;
        #1 chk("rstwait_async", {outVec, hz.MemErr}, {RST_O, 1'b0});
        mWait = 0; mHalted = 1'b0; mMemErr = 1'b0;
        @(negedge CLK);
        #1 chk("rstwait_next", {outVec, hz.MemErr}, {RST_O, 1'b0});
        drive(idle);
        @(negedge CLK);
        Reset_L = 1'b1;
        #1 chk("rstwait_release", {outVec, hz.MemErr}, {DEF_O, 1'b0});

        // timeout: MEM_TIMEOUT stalled cycles, then HALT with sticky MemErr
        for (int i = 0; i < MEM_TIMEOUT; i++) step(stall, MST_O, 1'b0, "tmo_wait");
        step(stall, RST_O, 1'b1, "tmo_halt");
        step(rdy,   RST_O, 1'b1, "halt_hold_rdy");
        step(tbl[6].v, RST_O, 1'b1, "halt_hold_jump");
        @(negedge CLK);
        Reset_L = 1'b0;
        #1 chk("halt_reset", {outVec, hz.MemErr}, {RST_O, 1'b0});
        mWait = 0; mHalted = 1'b0; mMemErr = 1'b0;
        @(negedge CLK);
        Reset_L = 1'b1;
        step(idle, DEF_O, 1'b0, "halt_exit_run");

        // randomized stimulus vs behavioural model
        for (int i = 0; i < 400; i++) begin
            rv.rs      = 5'($urandom_range(0, 7));
            rv.rt      = 5'($urandom_range(0, 7));
            rv.usesRt  = 1'($urandom_range(0, 1));
            rv.jump    = ($urandom_range(0, 3) == 0);
            rv.memRead = ($urandom_range(0, 1) == 0);
            rv.exRt    = 5'($urandom_range(0, 7));
            rv.br      = ($urandom_range(0, 4) == 0);
            rv.memReq  = ($urandom_range(0, 2) == 0);
            rv.ready   = 1'($urandom_range(0, 1));
            step(rv, modelOut(rv), mMemErr, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
